// File: rtl/fifo_stat_pkg.sv
// Shared helpers for the statistics FIFO: width arithmetic used to size the
// occupancy and watermark registers.
package fifo_stat_pkg;

  localparam int DEFAULT_FIFO_DEPTH_W = 2;
  localparam int DEFAULT_CNT_W        = DEFAULT_FIFO_DEPTH_W + 1;

  function automatic int clog2_int(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than a pointer.
  function automatic int count_width(input int depth_w);
    return clog2_int((1 << depth_w) + 1);
  endfunction

endpackage

// File: rtl/fifo_stat_buffer_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg;

  // Clear outranks a coincident increment so the clearing cycle is never counted.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/fifo_stat_buffer.sv
// First-word-fall-through FIFO with occupancy watermark, sticky overflow and
// underflow flags and saturating stall counters for buffer-sizing runs.
module fifo_stat_buffer
  import fifo_stat_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH_W = 2,
  parameter int AF_THRESH    = (1 << FIFO_DEPTH_W) - 1,
  parameter int AE_THRESH    = 1,
  parameter int STAT_W       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic                    wrdy_o,
  input  logic                    re_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    rrdy_o,
  output logic [FIFO_DEPTH_W:0]   count_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [FIFO_DEPTH_W:0]   max_count_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  output logic [STAT_W-1:0]       wstall_cnt_o,
  output logic [STAT_W-1:0]       rstall_cnt_o,
  input  logic                    clr_stats_i
);

  localparam int DEPTH = 1 << FIFO_DEPTH_W;
  localparam int CNT_W = count_width(FIFO_DEPTH_W);
  localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_DEPTH_W-1:0] PTR_ONE  = FIFO_DEPTH_W'(1);

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [FIFO_DEPTH_W-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;
  logic [CNT_W-1:0]        max_count_reg;
  logic [CNT_W-1:0]        max_count_next;
  logic                    overflow_reg;
  logic                    underflow_reg;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    wr_stall;
  logic                    rd_stall;

  // Ready flags come from registered occupancy only, never from the requests.
  assign wrdy_o   = (count_reg != CNT_FULL) & ~rst_i;
  assign rrdy_o   = (count_reg != '0) & ~rst_i;
  assign wr_acc   = we_i & wrdy_o;
  assign rd_acc   = re_i & rrdy_o;
  assign wr_stall = we_i & ~wrdy_o;
  assign rd_stall = re_i & ~rrdy_o;

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // A clear restarts the watermark from the occupancy the FIFO is about to hold.
  always_comb begin
    max_count_next = max_count_reg;
    if (clr_stats_i || (count_next > max_count_reg)) begin
      max_count_next = count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      max_count_reg <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg     <= count_next;
      max_count_reg <= max_count_next;
      if (clr_stats_i) begin
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (wr_stall) overflow_reg  <= 1'b1;
        if (rd_stall) underflow_reg <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(STAT_W)) u_wstall_cnt (
    .clk  (clk_i),
    .srst (rst_i),
    .inc  (wr_stall),
    .clr  (clr_stats_i),
    .cnt  (wstall_cnt_o)
  );

  sat_counter #(.WIDTH(STAT_W)) u_rstall_cnt (
    .clk  (clk_i),
    .srst (rst_i),
    .inc  (rd_stall),
    .clr  (clr_stats_i),
    .cnt  (rstall_cnt_o)
  );

  assign rdata_o        = mem[rd_ptr_reg];
  assign count_o        = count_reg;
  assign max_count_o    = max_count_reg;
  assign almost_full_o  = count_reg >= CNT_W'(AF_THRESH);
  assign almost_empty_o = count_reg <= CNT_W'(AE_THRESH);
  assign overflow_o     = overflow_reg;
  assign underflow_o    = underflow_reg;

endmodule

// File: tb/tb_fifo_stat_buffer.sv
// Randomised and directed checks of fifo_stat_buffer against a queue-based
// reference model; small stall counters make saturation reachable.
module tb_fifo_stat_buffer;

  localparam int DW      = 8;
  localparam int DEPTH_W = 2;
  localparam int DEPTH   = 4;
  localparam int CW      = 3;
  localparam int STAT_W  = 3;
  localparam int SAT_MAX = 7;
  localparam int AF      = 3;
  localparam int AE      = 1;

  logic              clk;
  logic              rst_i;
  logic              we_i;
  logic [DW-1:0]     wdata_i;
  logic              wrdy_o;
  logic              re_i;
  logic [DW-1:0]     rdata_o;
  logic              rrdy_o;
  logic [CW-1:0]     count_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [CW-1:0]     max_count_o;
  logic              overflow_o;
  logic              underflow_o;
  logic [STAT_W-1:0] wstall_cnt_o;
  logic [STAT_W-1:0] rstall_cnt_o;
  logic              clr_stats_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int  m_max, m_ws, m_rs;
  bit  m_of, m_uf;

  fifo_stat_buffer #(
    .DATA_W(DW), .FIFO_DEPTH_W(DEPTH_W), .AF_THRESH(AF), .AE_THRESH(AE), .STAT_W(STAT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .wdata_i(wdata_i), .wrdy_o(wrdy_o),
    .re_i(re_i), .rdata_o(rdata_o), .rrdy_o(rrdy_o), .count_o(count_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .max_count_o(max_count_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .wstall_cnt_o(wstall_cnt_o), .rstall_cnt_o(rstall_cnt_o), .clr_stats_i(clr_stats_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit rst, input bit we, input logic [DW-1:0] wd,
                      input bit re, input bit clr);
    bit wr_ok, rd_ok;
    rst_i = rst; we_i = we; wdata_i = wd; re_i = re; clr_stats_i = clr;
    if (rst) begin
      q.delete();
      m_max = 0; m_ws = 0; m_rs = 0; m_of = 0; m_uf = 0;
    end else begin
      wr_ok = we && (q.size() < DEPTH);
      rd_ok = re && (q.size() > 0);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(wd);
      if (clr) begin
        m_of = 0; m_uf = 0; m_ws = 0; m_rs = 0; m_max = q.size();
      end else begin
        if (we && !wr_ok) begin m_of = 1; if (m_ws < SAT_MAX) m_ws++; end
        if (re && !rd_ok) begin m_uf = 1; if (m_rs < SAT_MAX) m_rs++; end
        if (q.size() > m_max) m_max = q.size();
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 8'hA5, 1, 0);
      checks++;
      if (wrdy_o !== 1'b0 || rrdy_o !== 1'b0) begin
        errors++; $display("FAIL reset_rdy got wrdy=%b rrdy=%b want 0 0", wrdy_o, rrdy_o);
      end
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (wrdy_o !== 1'b1 || rrdy_o !== 1'b0 || almost_empty_o !== 1'b1 || almost_full_o !== 1'b0) begin
      errors++; $display("FAIL reset_release got wrdy=%b rrdy=%b ae=%b af=%b want 1 0 1 0",
                         wrdy_o, rrdy_o, almost_empty_o, almost_full_o);
    end
    checks++;
    if (count_o !== 3'd0 || max_count_o !== 3'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0 ||
        wstall_cnt_o !== 3'd0 || rstall_cnt_o !== 3'd0) begin
      errors++; $display("FAIL reset_stats got cnt=%0d max=%0d of=%b uf=%b ws=%0d rs=%0d want all 0",
                         count_o, max_count_o, overflow_o, underflow_o, wstall_cnt_o, rstall_cnt_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      exp_d = DW'((i + 1) * 17);
      step(0, 1, exp_d, 0, 0);
      checks++;
      if (count_o !== CW'(i + 1) || almost_full_o !== (i + 1 >= AF) ||
          wrdy_o !== (i < 3) || max_count_o !== CW'(i + 1)) begin
        errors++; $display("FAIL fill[%0d] got cnt=%0d af=%b wrdy=%b max=%0d want %0d %b %b %0d",
                           i, count_o, almost_full_o, wrdy_o, max_count_o,
                           i + 1, (i + 1 >= AF), (i < 3), i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = DW'((i + 1) * 17);
      checks++;
      if (rdata_o !== exp_d || rrdy_o !== 1'b1) begin
        errors++; $display("FAIL drain_data[%0d] got %h rrdy=%b want %h 1", i, rdata_o, rrdy_o, exp_d);
      end
      step(0, 0, 0, 1, 0);
      checks++;
      if (count_o !== CW'(3 - i) || almost_empty_o !== (3 - i <= AE) || rrdy_o !== (i < 3)) begin
        errors++; $display("FAIL drain[%0d] got cnt=%0d ae=%b rrdy=%b want %0d %b %b",
                           i, count_o, almost_empty_o, rrdy_o, 3 - i, (3 - i <= AE), (i < 3));
      end
    end
    $display("test_fill_drain done");
  endtask

  task automatic test_full_both();
    logic [DW-1:0] second;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, DW'($urandom), 0, 0);
    second = q[1];
    step(0, 1, 8'hEE, 1, 0);
    checks++;
    if (count_o !== 3'd3 || overflow_o !== 1'b1 || wstall_cnt_o !== 3'd1 || rdata_o !== second) begin
      errors++; $display("FAIL full_both got cnt=%0d of=%b ws=%0d head=%h want 3 1 1 %h",
                         count_o, overflow_o, wstall_cnt_o, rdata_o, second);
    end
    $display("test_full_both done");
  endtask

  task automatic test_underflow_clear();
    while (q.size() > 0) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    checks++;
    if (underflow_o !== 1'b1 || rstall_cnt_o !== 3'd5 || count_o !== 3'd0) begin
      errors++; $display("FAIL underflow got uf=%b rs=%0d cnt=%0d want 1 5 0",
                         underflow_o, rstall_cnt_o, count_o);
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if (underflow_o !== 1'b0 || rstall_cnt_o !== 3'd0 || overflow_o !== 1'b0 || wstall_cnt_o !== 3'd0) begin
      errors++; $display("FAIL clear_stats got uf=%b rs=%0d of=%b ws=%0d want 0 0 0 0",
                         underflow_o, rstall_cnt_o, overflow_o, wstall_cnt_o);
    end
    $display("test_underflow_clear done");
  endtask

  task automatic test_streaming();
    step(0, 1, DW'($urandom), 0, 0);
    step(0, 1, DW'($urandom), 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, DW'($urandom), 1, 0);
      checks++;
      if (count_o !== 3'd2 || rdata_o !== q[0] || wstall_cnt_o !== 3'd0 || rstall_cnt_o !== 3'd0) begin
        errors++; $display("FAIL stream[%0d] got cnt=%0d head=%h ws=%0d rs=%0d want 2 %h 0 0",
                           i, count_o, rdata_o, wstall_cnt_o, rstall_cnt_o, q[0]);
      end
    end
    $display("test_streaming done");
  endtask

  task automatic test_saturation();
    while (q.size() < DEPTH) step(0, 1, DW'($urandom), 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, DW'($urandom), 0, 0);
      checks++;
      if (wstall_cnt_o !== STAT_W'((i + 1 < SAT_MAX) ? i + 1 : SAT_MAX)) begin
        errors++; $display("FAIL saturate[%0d] got ws=%0d want %0d", i, wstall_cnt_o,
                           (i + 1 < SAT_MAX) ? i + 1 : SAT_MAX);
      end
    end
    $display("test_saturation done");
  endtask

  task automatic test_random();
    bit we, re, clr;
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom_range(0, 99) < 55);
      re  = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 99) < 4);
      step(0, we, DW'($urandom), re, clr);
      checks++;
      if (count_o !== CW'(q.size()) || max_count_o !== CW'(m_max) ||
          wrdy_o !== (q.size() < DEPTH) || rrdy_o !== (q.size() > 0) ||
          almost_full_o !== (q.size() >= AF) || almost_empty_o !== (q.size() <= AE) ||
          overflow_o !== m_of || underflow_o !== m_uf ||
          wstall_cnt_o !== STAT_W'(m_ws) || rstall_cnt_o !== STAT_W'(m_rs) ||
          (q.size() > 0 && rdata_o !== q[0])) begin
        errors++;
        $display("FAIL random[%0d] got cnt=%0d max=%0d of=%b uf=%b ws=%0d rs=%0d d=%h want %0d %0d %b %b %0d %0d %h",
                 i, count_o, max_count_o, overflow_o, underflow_o, wstall_cnt_o, rstall_cnt_o,
                 rdata_o, q.size(), m_max, m_of, m_uf, m_ws, m_rs, (q.size() > 0) ? q[0] : 8'h00);
      end
    end
    $display("test_random done");
  endtask

  task automatic test_mid_reset();
    while (q.size() > 3) step(0, 0, 0, 1, 0);
    while (q.size() < 3) step(0, 1, DW'($urandom), 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, DW'($urandom), 1, 0);
    step(0, 1, DW'($urandom), 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, DW'($urandom), 1, 0);
      checks++;
      if (wrdy_o !== 1'b0 || rrdy_o !== 1'b0) begin
        errors++; $display("FAIL midreset_rdy[%0d] got wrdy=%b rrdy=%b want 0 0", i, wrdy_o, rrdy_o);
      end
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (count_o !== 3'd0 || max_count_o !== 3'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0 ||
        wstall_cnt_o !== 3'd0 || rstall_cnt_o !== 3'd0 || rrdy_o !== 1'b0 || wrdy_o !== 1'b1) begin
      errors++; $display("FAIL midreset_after got cnt=%0d max=%0d of=%b uf=%b ws=%0d rs=%0d rrdy=%b wrdy=%b",
                         count_o, max_count_o, overflow_o, underflow_o, wstall_cnt_o,
                         rstall_cnt_o, rrdy_o, wrdy_o);
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    rst_i = 1'b1; we_i = 1'b0; wdata_i = '0; re_i = 1'b0; clr_stats_i = 1'b0;
    m_max = 0; m_ws = 0; m_rs = 0; m_of = 0; m_uf = 0;
    test_reset();
    test_fill_drain();
    test_full_both();
    test_underflow_clear();
    test_streaming();
    test_saturation();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
